// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity
// selectors and the parity helper shared with the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Words narrower than 32 bits are zero-extended by the caller.
  function automatic logic parity(
    input logic [31:0] word,
    input logic        typ
  );
    return (^word) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period timer for the UART transmitter: cycle counter,
// end-of-bit pulse and data bit index.
module tx_baud_counter #(
  parameter int DATA_WIDTH  = 8,
  parameter int scale_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      count_bits,
  input  logic [scale_WIDTH-1:0]    period,
  output logic                      bit_end,
  output logic [$clog2(DATA_WIDTH):0] bit_idx
);

  logic [scale_WIDTH-1:0] count;
  logic [scale_WIDTH-1:0] last;

  // A zero period behaves like a one-cycle bit.
  assign last = (period == '0) ? '0 : period - 1'b1;
  assign bit_end = enable && (count == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      bit_idx <= '0;
    end else if (!enable) begin
      count   <= '0;
      bit_idx <= '0;
    end else if (count == last) begin
      count <= '0;
      if (count_bits)
        bit_idx <= bit_idx + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity and
// one stop bit, each held for a latched number of clk cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int scale_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [scale_WIDTH-1:0] prescaler,
  output logic                   TX_OUT,
  output logic                   busy
);

  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  tx_state_t state, next;

  logic [DATA_WIDTH-1:0]  shreg;
  logic                   par_en_q;
  logic                   par_q;
  logic [scale_WIDTH-1:0] period_q;
  logic                   bit_end;
  logic [IW-1:0]          bit_idx;
  logic                   accept;
  logic                   line;

  assign accept = (state == IDLE) && Data_Valid;

  tx_baud_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .scale_WIDTH(scale_WIDTH)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .enable    (state != IDLE),
    .count_bits(state == DATA),
    .period    (period_q),
    .bit_end   (bit_end),
    .bit_idx   (bit_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    line = 1'b1;
    unique case (state)
      IDLE:   if (Data_Valid) next = START;
      START: begin
        line = 1'b0;
        if (bit_end) next = DATA;
      end
      DATA: begin
        line = shreg[0];
        if (bit_end && bit_idx == LAST_IDX)
          next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        line = par_q;
        if (bit_end) next = STOP;
      end
      STOP:   if (bit_end) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs are registered copies of the current state's line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      period_q <= '0;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      TX_OUT <= line;
      busy   <= (state != IDLE);
      if (accept) begin
        shreg    <= P_DATA;
        par_en_q <= PAR_EN;
        par_q    <= parity(32'(P_DATA), PAR_TYP);
        period_q <= prescaler;
      end else if (state == DATA && bit_end) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed vector table, random
// frames against a bit-list model, and hand-written corner cases.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic          dv = 1'b0;
  logic          pe = 1'b0;
  logic          pt = 1'b0;
  logic [SW-1:0] ps = '0;
  logic          tx_out;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_bits[$];

  uart_tx #(
    .DATA_WIDTH (DW),
    .scale_WIDTH(SW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .P_DATA    (p_data),
    .Data_Valid(dv),
    .PAR_EN    (pe),
    .PAR_TYP   (pt),
    .prescaler (ps),
    .TX_OUT    (tx_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic int period(input logic [SW-1:0] s);
    return (s == 0) ? 1 : int'(s);
  endfunction

  // Frame as a list of line levels, one entry per bit.
  function automatic void model(input logic [DW-1:0] d,
                                input logic e, input logic t);
    int ones;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(d[i]);
    ones = $countones(d);
    if (e) exp_bits.push_back(((ones % 2) == 1) != t);
    exp_bits.push_back(1'b1);
  endfunction

  task automatic frame(input logic [DW-1:0] d, input logic e,
                       input logic t, input logic [SW-1:0] s,
                       input int inj, output int blen,
                       output logic par_seen,
                       output logic [DW-1:0] dec);
    int p, n, b;
    model(d, e, t);
    p = period(s);
    n = exp_bits.size() * p;
    @(negedge clk);
    p_data = d; pe = e; pt = t; ps = s; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    @(negedge clk);
    check("latency_tx", tx_out, 1);
    check("latency_busy", busy, 0);
    blen = 0; dec = '0; par_seen = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("frame_tx", tx_out, exp_bits[c / p]);
      if (busy) blen++;
      b = c / p;
      if (c % p == 0) begin
        if (b >= 1 && b <= DW) dec[b-1] = tx_out;
        if (e && b == DW + 1) par_seen = tx_out;
      end
      if (c == inj) begin
        p_data = '0; pt = ~t; dv = 1'b1;
      end else begin
        dv = 1'b0;
      end
    end
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_tx", tx_out, 1);
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    logic          t;
    logic [SW-1:0] s;
    int            len;
    logic          par;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int blen, p, n;
    logic par;
    logic [DW-1:0] dec, rd;
    logic re, rt;
    logic [SW-1:0] rs;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  80,  1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b0, 6'd16, 176, 1'b1};
    tbl[2] = '{8'h07, 1'b1, 1'b1, 6'd16, 176, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 6'd0,  10,  1'b0};

    #1 reset = 1'b1;
    #2;
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_tx", tx_out, 1);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 4; i++) begin
      frame(tbl[i].d, tbl[i].e, tbl[i].t, tbl[i].s, -1,
            blen, par, dec);
      check("busy_len", blen, tbl[i].len);
      check("decoded", dec, tbl[i].d);
      if (tbl[i].e) check("parity", par, tbl[i].par);
    end

    for (int i = 0; i < 20; i++) begin
      rd = DW'($urandom);
      re = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      rs = SW'($urandom_range(0, 5));
      frame(rd, re, rt, rs, -1, blen, par, dec);
      check("rand_len", blen, exp_bits.size() * period(rs));
      check("rand_data", dec, rd);
    end

    frame(8'hFF, 1'b1, 1'b0, 6'd4, 10, blen, par, dec);
    check("ignore_data", dec, 8'hFF);
    check("ignore_par", par, 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("no_second", {busy, tx_out}, 2'b01);
    end

    model(8'h3C, 1'b0, 1'b0);
    p = 2;
    n = exp_bits.size() * p;
    @(negedge clk);
    p_data = 8'h3C; pe = 1'b0; pt = 1'b0; ps = 6'd2; dv = 1'b1;
    @(negedge clk);
    check("b2b_latency", tx_out, 1);
    for (int f = 0; f < 3; f++) begin
      dec = '0;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (f == 2) dv = 1'b0;
        check("b2b_tx", tx_out, exp_bits[c / p]);
        if (c % p == 0 && c / p >= 1 && c / p <= DW)
          dec[c/p-1] = tx_out;
      end
      check("b2b_byte", dec, 8'h3C);
      @(negedge clk);
      check("b2b_gap", {busy, tx_out}, 2'b01);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("b2b_idle", {busy, tx_out}, 2'b01);
    end

    model(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    p_data = 8'hA5; pe = 1'b0; ps = 6'd4; dv = 1'b1;
    @(posedge clk);
    #1 dv = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("pre_reset_tx", tx_out, exp_bits[c / 4]);
    end
    #2 reset = 1'b1;
    #1;
    check("async_tx", tx_out, 1);
    check("async_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("post_reset_idle", {busy, tx_out}, 2'b01);
    end
    frame(8'h96, 1'b1, 1'b1, 6'd3, -1, blen, par, dec);
    check("recover_data", dec, 8'h96);
    check("recover_par", par, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
